right_rotate_pipe: RTL
======================

RIGHT_ROTATE_PIPE -- requirements
Module: right_rotate_pipe

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits.
REQ-002 SHALL have parameter C, default 4, rotate-count width; N = 2**C.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port In  input  N  operand.
REQ-006 SHALL have port Cnt  input  C  right-rotate amount, 0..N-1.
REQ-007 SHALL have port in_valid  input  1  In/Cnt valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts In/Cnt this cycle.
REQ-009 SHALL have port Out  output  N  rotated result.
REQ-010 SHALL have port out_valid  output  1  Out holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes Out this cycle.
REQ-012 SHALL have port occupancy  output  3  number of valid stages, 0..4.

Function
REQ-013 SHALL compute Out = In rotated right by Cnt: bit i of Out = In[(i+Cnt) mod N].
REQ-014 SHALL use four registered stages: S1 rotates by 8 if Cnt[3], S2 by 4 if Cnt[2], S3 by 2 if Cnt[1], S4 by 1 if Cnt[0].
REQ-015 SHALL carry the unused Cnt bits and a valid bit with each stage's data.
REQ-016 SHALL accept input on the rising edge where in_valid and in_ready are both 1; transfer out on the edge where out_valid and out_ready are both 1.
REQ-017 SHALL give latency of exactly 4 cycles from acceptance to out_valid when unstalled; throughput 1 result per cycle.
REQ-018 SHALL advance stage k when stage k is empty or stage k+1 advances; S4 advances when empty or out_ready=1.
REQ-019 SHALL drive in_ready = (S1 empty) or (S1 advances); combinational from out_ready allowed, no combinational path from in_valid.
REQ-020 SHALL hold every stage's data, count and valid unchanged when that stage does not advance; no result lost or duplicated under any stall pattern.
REQ-021 SHALL drive out_valid from S4 valid and Out from S4 data register, with no combinational logic after the register.
REQ-022 SHALL drive Out stable while out_valid=1 and out_ready=0.
REQ-023 SHALL treat Cnt=0 as pass-through with the same 4-cycle latency.
REQ-024 SHALL keep occupancy equal to the count of set stage valid bits; 4 means full, and then in_ready equals out_ready.
REQ-025 SHALL, on a simultaneous accept and deliver when full, keep occupancy at 4.

Reset
REQ-026 SHALL, while rst_n=0, clear all stage valid bits, data and count registers to 0, independent of clk.
REQ-027 SHALL drive Out=0, out_valid=0, occupancy=0 and in_ready=1 after reset.
REQ-028 SHALL discard in-flight operations on reset mid-operation; none appear after release.
REQ-029 SHALL accept input on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL take N, C and stage rotate amounts (8,4,2,1) from the shared constants file used by the shifter blocks.
REQ-031 SHALL instantiate one sub-module, right_rotate_stage (parameter AMT), four times; it holds the valid/data/count register and conditional rotate by AMT, using the existing mux2_1 for selection.
REQ-032 SHALL fit within 120-400 lines of RTL, excluding comments.

Verification
REQ-033 SHALL check In=0x1234, Cnt=4, out_ready=1 -> Out=0x4123, out_valid=1 exactly 4 cycles after acceptance.
REQ-034 SHALL check In=0x8001, Cnt=15 -> Out=0x0003; and In=0xABCD, Cnt=8 -> Out=0xCDAB; and In=0xBEEF, Cnt=0 -> Out=0xBEEF.
REQ-035 SHALL check 6 back-to-back inputs with out_ready=0: occupancy reaches 4, then in_ready=0; Out holds the first result. After out_ready=1, all 6 results appear in order, one per cycle.
REQ-036 SHALL check full pipe with in_valid=1 and out_ready=1 -> occupancy stays 4, one result per cycle, in_ready=1.
REQ-037 SHALL check rst_n pulsed low mid-stream with 3 operations in flight -> out_valid=0, occupancy=0 immediately, and no stale results after release.
REQ-038 SHALL check 1000 random In/Cnt/out_ready/in_valid cycles against the REQ-013 reference model, with in-order, lossless delivery.

Source files
------------

// File: rtl/right_rotate_pipe_pkg.sv
// Shared constants for the right-rotate pipeline and its sibling shifters.
// Default width, count width and per-stage rotate amounts.
package right_rotate_pipe_pkg;

    localparam int RR_N = 16;
    localparam int RR_C = 4;

    localparam int RR_AMT_S1 = 8;
    localparam int RR_AMT_S2 = 4;
    localparam int RR_AMT_S3 = 2;
    localparam int RR_AMT_S4 = 1;

endpackage

// File: rtl/mux2_1.sv
// Generic two-input multiplexer shared by the shifter blocks.
// sel=0 passes a, sel=1 passes b.
module mux2_1 #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/right_rotate_pipe_stage.sv
// One registered rotate stage: rotates right by AMT when the
// matching count bit is set, carrying valid and count alongside.
module right_rotate_stage
    import right_rotate_pipe_pkg::*;
#(
    parameter int N   = RR_N,
    parameter int C   = RR_C,
    parameter int AMT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    input  logic         validIn,
    input  logic [N-1:0] dataIn,
    input  logic [C-1:0] cntIn,
    output logic         validOut,
    output logic [N-1:0] dataOut,
    output logic [C-1:0] cntOut
);

    localparam int SEL = $clog2(AMT);

    logic [N-1:0] rotated;
    logic [N-1:0] selected;

    assign rotated = {dataIn[AMT-1:0], dataIn[N-1:AMT]};

    mux2_1 #(
        .W(N)
    ) uMux (
        .sel(cntIn[SEL]),
        .a  (dataIn),
        .b  (rotated),
        .y  (selected)
    );

    // Load a new operation on advance; hold everything otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validOut <= 1'b0;
            dataOut  <= '0;
            cntOut   <= '0;
        end else if (advance) begin
            validOut <= validIn;
            if (validIn) begin
                dataOut <= selected;
                cntOut  <= cntIn;
            end
        end
    end

endmodule

// File: rtl/right_rotate_pipe.sv
// Four-stage pipelined right rotator with valid/ready flow control.
// Stages rotate by 8, 4, 2, 1 under control of Cnt[3..0].
module right_rotate_pipe
    import right_rotate_pipe_pkg::*;
#(
    parameter int N = RR_N,
    parameter int C = RR_C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] In,
    input  logic [C-1:0] Cnt,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   occupancy
);

    logic         s1Valid, s2Valid, s3Valid, s4Valid;
    logic [N-1:0] s1Data, s2Data, s3Data, s4Data;
    logic [C-1:0] s1Cnt, s2Cnt, s3Cnt, s4Cnt;
    logic         adv1, adv2, adv3, adv4;
    logic         unusedCnt;

    // A stage moves when it is empty or its successor moves.
    assign adv4 = !s4Valid || out_ready;
    assign adv3 = !s3Valid || adv4;
    assign adv2 = !s2Valid || adv3;
    assign adv1 = !s1Valid || adv2;

    assign in_ready  = adv1;
    assign out_valid = s4Valid;
    assign Out       = s4Data;
    assign unusedCnt = ^s4Cnt;

    assign occupancy = 3'(s1Valid) + 3'(s2Valid)
                     + 3'(s3Valid) + 3'(s4Valid);

    right_rotate_stage #(
        .N(N), .C(C), .AMT(RR_AMT_S1)
    ) uS1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (adv1),
        .validIn (in_valid),
        .dataIn  (In),
        .cntIn   (Cnt),
        .validOut(s1Valid),
        .dataOut (s1Data),
        .cntOut  (s1Cnt)
    );

    right_rotate_stage #(
        .N(N), .C(C), .AMT(RR_AMT_S2)
    ) uS2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (adv2),
        .validIn (s1Valid),
        .dataIn  (s1Data),
        .cntIn   (s1Cnt),
        .validOut(s2Valid),
        .dataOut (s2Data),
        .cntOut  (s2Cnt)
    );

    right_rotate_stage #(
        .N(N), .C(C), .AMT(RR_AMT_S3)
    ) uS3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (adv3),
        .validIn (s2Valid),
        .dataIn  (s2Data),
        .cntIn   (s2Cnt),
        .validOut(s3Valid),
        .dataOut (s3Data),
        .cntOut  (s3Cnt)
    );

    right_rotate_stage #(
        .N(N), .C(C), .AMT(RR_AMT_S4)
    ) uS4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (adv4),
        .validIn (s3Valid),
        .dataIn  (s3Data),
        .cntIn   (s3Cnt),
        .validOut(s4Valid),
        .dataOut (s4Data),
        .cntOut  (s4Cnt)
    );

endmodule
